uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  Host-command front end for the phase capture dump path. Receives 8N1 bytes on fpga_rx,
//  the counterpart of acia_tx. Decodes single-byte commands into a clean 1-cycle dump_req
//  pulse and an armed level. dump_req replaces the raw fpga_rx level trigger of the
//  capture/dump block. Sits between the FPGA RX pin and the capture/dump stage.
// PARAMETERS
//  sym_cnt   40000  clocks per UART bit (48 MHz / 1200 baud)
//  SCW       16     bit-rate counter width, = $clog2(sym_cnt)
//  CMD_DUMP  8'h44  'D': request one capture dump
//  CMD_ARM   8'h41  'A': set armed
//  CMD_DISARM 8'h58 'X': clear armed
//  ARM_RST   1      armed value after reset
// PORTS
//  clk       in   1  system clock, 48 MHz
//  rst       in   1  synchronous reset, active-high
//  fpga_rx   in   1  asynchronous UART serial input, idle high
//  rx_dat    out  8  last received byte, valid while rx_stb=1, held afterwards
//  rx_stb    out  1  1-cycle pulse: good byte received (stop bit = 1)
//  rx_ferr   out  1  1-cycle pulse: framing error (stop bit = 0)
//  dump_req  out  1  1-cycle pulse: CMD_DUMP received while armed
//  armed     out  1  level: dump requests enabled
//  rx_busy   out  1  receiver is not in IDLE
// BEHAVIOUR
//  - Reset: rx_dat=0, rx_stb=0, rx_ferr=0, dump_req=0, armed=ARM_RST, rx_busy=0, FSM=IDLE.
//    The synchronizer flops reset to 1. Reset mid-frame discards the partial byte.
//  - Input: 2-FF synchronizer gives rx_s, plus a delayed copy rx_d. A falling edge is
//    rx_d=1 && rx_s=0. Pin-to-FSM latency is 2 clk.
//  - Bit counter bcnt[SCW-1:0] counts down. A "tick" is bcnt==0.
//  - FSM states: IDLE, START, DATA, STOP, BREAK.
//    IDLE : on falling edge -> START, bcnt=sym_cnt/2-1.
//    START: at tick, if rx_s=0 -> DATA, bcnt=sym_cnt-1, idx=0.
//           If rx_s=1 (glitch) -> IDLE; no pulse.
//    DATA : at tick, shift rx_s into sr, LSB first, and reload bcnt=sym_cnt-1.
//           After idx=7 is sampled -> STOP.
//    STOP : at tick, if rx_s=1 -> rx_dat<=sr, rx_stb=1 for 1 clk, -> IDLE.
//           If rx_s=0 -> rx_ferr=1 for 1 clk, -> BREAK.
//    BREAK: wait for rx_s=1 -> IDLE. Covers a line held low or a break condition.
//  - A new start edge is accepted in the first IDLE cycle after STOP, so back-to-back
//    frames are received.
//  - rx_busy = (state != IDLE).
//  - Decode happens in the cycle after rx_stb, registered, using rx_dat:
//    CMD_DUMP && armed -> dump_req=1 for exactly 1 clk (rx_stb to dump_req: 1 clk).
//    CMD_DUMP && !armed -> ignored.
//    CMD_ARM -> armed=1. CMD_DISARM -> armed=0. Any other byte -> no effect.
//  - Framing-error bytes are never decoded.
//  - The consumer ignores dump_req while a dump is already in progress. This block does
//    not queue requests: every good 'D' produces a pulse.
//  - The midpoint sample uses sym_cnt/2 with integer truncation. sym_cnt must be >= 4.
// STRUCTURE
//  - Shared package/header: clk_freq=48000000, sym_rate=1200, sym_cnt, SCW. These are
//    shared with acia_tx instantiations. CMD_* byte codes are also shared with host scripts.
//  - Sub-module acia_rx holds the synchronizer, FSM and bit counter, with ports clk, rst,
//    rx_serial, rx_dat, rx_stb, rx_ferr, rx_busy. It mirrors acia_tx.
//  - uart_cmd_rx = acia_rx + command decode and armed register.
// TESTING  (bench overrides sym_cnt=16, SCW=4)
//  1. Send 0x44, armed after reset -> rx_stb once with rx_dat=0x44;
//     dump_req exactly 1 clk, 1 clk after rx_stb.
//  2. Send 0x58 then 0x44 -> armed falls after the first byte;
//     rx_stb fires twice; dump_req never asserts. Then 0x41, 0x44 -> one dump_req.
//  3. Send 0x55 with stop bit forced 0 -> rx_ferr 1 clk, no rx_stb, rx_busy stays 1
//     until the line returns high, then 0x44 is received normally.
//  4. Low glitch of 3 clk on idle line -> no rx_stb/rx_ferr, FSM back to IDLE
//     within sym_cnt/2+3 clk.
//  5. Two frames 0xA5, 0x44 back-to-back, no idle gap ->
//     both bytes received in order, one dump_req.
//  6. Assert rst during DATA of a 0x44 frame -> all outputs at reset values next clk,
//     no dump_req; the following full 0x44 frame is received correctly.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// uart_cmd_rx_pkg: shared UART rate constants, host command codes and receiver states
package uart_cmd_rx_pkg;
    localparam int CLK_FREQ = 48000000;
    localparam int SYM_RATE = 1200;
    localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
    localparam int SYM_W = $clog2(SYM_CNT);
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_ARM = 8'h41;
    localparam logic [7:0] CMD_DISARM = 8'h58;
    localparam logic ARM_RST = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_e;
endpackage

// File: rtl/acia_rx.sv
// acia_rx: 8N1 UART receiver with 2-FF synchronizer, mid-bit sampling and break recovery
module acia_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int sym_cnt = SYM_CNT,
    parameter int SCW = SYM_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_ferr,
    output logic       rx_busy
);
    localparam logic [SCW-1:0] HALF = SCW'(sym_cnt / 2 - 1);
    localparam logic [SCW-1:0] FULL = SCW'(sym_cnt - 1);

    rx_state_e      state_q, state_d;
    logic [2:0]     sync_q, sync_d;
    logic [SCW-1:0] bcnt_q, bcnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     sr_q, sr_d, dat_q, dat_d;
    logic           stb_q, stb_d, ferr_q, ferr_d;
    logic           rx_s, rx_d, tick;

    assign rx_s = sync_q[1];
    assign rx_d = sync_q[2];
    assign tick = bcnt_q == '0;
    assign rx_dat = dat_q;
    assign rx_stb = stb_q;
    assign rx_ferr = ferr_q;
    assign rx_busy = state_q != ST_IDLE;

    // Next-state: sync shift, bit timing, shift register and frame result pulses
    always_comb begin
        sync_d = {sync_q[1:0], rx_serial};
        state_d = state_q;
        bcnt_d = bcnt_q - 1'b1;
        idx_d = idx_q;
        sr_d = sr_q;
        dat_d = dat_q;
        stb_d = 1'b0;
        ferr_d = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_d && !rx_s) begin
                state_d = ST_START;
                bcnt_d = HALF;
            end
            ST_START: if (tick) begin
                state_d = rx_s ? ST_IDLE : ST_DATA;
                bcnt_d = FULL;
                idx_d = '0;
            end
            ST_DATA: if (tick) begin
                sr_d = {rx_s, sr_q[7:1]};
                bcnt_d = FULL;
                idx_d = idx_q + 1'b1;
                state_d = idx_q == 3'd7 ? ST_STOP : ST_DATA;
            end
            ST_STOP: if (tick) begin
                state_d = rx_s ? ST_IDLE : ST_BREAK;
                dat_d = rx_s ? sr_q : dat_q;
                stb_d = rx_s;
                ferr_d = !rx_s;
            end
            ST_BREAK: state_d = rx_s ? ST_IDLE : ST_BREAK;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; synchronizer resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sync_q <= '1;
            bcnt_q <= '0;
            idx_q <= '0;
            sr_q <= '0;
            dat_q <= '0;
            stb_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            bcnt_q <= bcnt_d;
            idx_q <= idx_d;
            sr_q <= sr_d;
            dat_q <= dat_d;
            stb_q <= stb_d;
            ferr_q <= ferr_d;
        end
    end
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver plus single-byte command decode into dump_req pulse and armed level
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int sym_cnt = SYM_CNT,
    parameter int SCW = SYM_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fpga_rx,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_ferr,
    output logic       dump_req,
    output logic       armed,
    output logic       rx_busy
);
    logic dump_q, dump_d, armed_q, armed_d;

    acia_rx #(.sym_cnt(sym_cnt), .SCW(SCW)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_serial(fpga_rx),
        .rx_dat   (rx_dat),
        .rx_stb   (rx_stb),
        .rx_ferr  (rx_ferr),
        .rx_busy  (rx_busy)
    );

    assign dump_req = dump_q;
    assign armed = armed_q;

    // Decode the byte presented with rx_stb; framing errors never raise rx_stb
    always_comb begin
        dump_d = rx_stb && rx_dat == CMD_DUMP && armed_q;
        armed_d = !rx_stb ? armed_q :
                  rx_dat == CMD_ARM ? 1'b1 :
                  rx_dat == CMD_DISARM ? 1'b0 : armed_q;
    end

    // Command result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_q <= 1'b0;
            armed_q <= ARM_RST;
        end else begin
            dump_q <= dump_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed and random frames checked against a byte/command-level model
module tb_uart_cmd_rx;
    import uart_cmd_rx_pkg::*;
    localparam int SC = 16;

    logic clk = 1'b0, rst = 1'b1, fpga_rx = 1'b1;
    logic [7:0] rx_dat;
    logic rx_stb, rx_ferr, dump_req, armed, rx_busy;

    int vectors = 0, miscompares = 0, cyc = 0, ferr_n = 0;
    logic [7:0] stb_b[$];
    int stb_t[$], dump_t[$];
    logic [7:0] exp_b[$];
    bit exp_d[$];
    bit m_armed = ARM_RST;

    always #5 clk = ~clk;

    uart_cmd_rx #(.sym_cnt(SC), .SCW(4)) dut (
        .clk(clk), .rst(rst), .fpga_rx(fpga_rx), .rx_dat(rx_dat), .rx_stb(rx_stb),
        .rx_ferr(rx_ferr), .dump_req(dump_req), .armed(armed), .rx_busy(rx_busy)
    );

    // Event recorder sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_stb) begin
            stb_b.push_back(rx_dat);
            stb_t.push_back(cyc);
        end
        if (dump_req) dump_t.push_back(cyc);
        if (rx_ferr) ferr_n++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        fpga_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic v);
        fpga_rx = v;
        repeat (SC) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        if (stop) begin
            exp_b.push_back(b);
            exp_d.push_back(b == CMD_DUMP && m_armed);
            if (b == CMD_ARM) m_armed = 1'b1;
            if (b == CMD_DISARM) m_armed = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (rx_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rx_busy, 0);
    endtask

    task automatic clear_obs();
        stb_b.delete();
        stb_t.delete();
        dump_t.delete();
        exp_b.delete();
        exp_d.delete();
        ferr_n = 0;
    endtask

    task automatic check_batch(input string tag);
        int exp_dt[$];
        chk({tag, "_nstb"}, stb_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < stb_b.size(); i++) begin
            chk($sformatf("%s_dat%0d", tag, i), stb_b[i], exp_b[i]);
            if (exp_d[i]) exp_dt.push_back(stb_t[i] + 1);
        end
        chk({tag, "_ndump"}, dump_t.size(), exp_dt.size());
        for (int i = 0; i < exp_dt.size() && i < dump_t.size(); i++)
            chk($sformatf("%s_dumpt%0d", tag, i), dump_t[i], exp_dt[i]);
        chk({tag, "_ferr"}, ferr_n, 0);
        chk({tag, "_armed"}, armed, m_armed);
        clear_obs();
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("rst_dat", rx_dat, 0);
        chk("rst_stb", rx_stb, 0);
        chk("rst_ferr", rx_ferr, 0);
        chk("rst_dump", dump_req, 0);
        chk("rst_armed", armed, ARM_RST);
        chk("rst_busy", rx_busy, 0);
        rst = 1'b0;
        idle(SC);
        clear_obs();
        send(CMD_DUMP, 1'b1);
        idle(4);
        check_batch("t1");
        send(CMD_DISARM, 1'b1);
        send(CMD_DUMP, 1'b1);
        idle(4);
        check_batch("t2a");
        send(CMD_ARM, 1'b1);
        send(CMD_DUMP, 1'b1);
        idle(4);
        check_batch("t2b");
        send(8'h55, 1'b0);
        repeat (2 * SC) @(negedge clk);
        chk("t3_busy_low", rx_busy, 1);
        chk("t3_ferr_n", ferr_n, 1);
        chk("t3_no_stb", stb_b.size(), 0);
        fpga_rx = 1'b1;
        wait_idle("t3_idle", 5);
        idle(SC);
        ferr_n = 0;
        send(CMD_DUMP, 1'b1);
        idle(4);
        check_batch("t3");
        fpga_rx = 1'b0;
        repeat (3) @(negedge clk);
        fpga_rx = 1'b1;
        wait_idle("t4_idle", SC / 2);
        idle(SC);
        check_batch("t4");
        send(8'hA5, 1'b1);
        send(CMD_DUMP, 1'b1);
        idle(4);
        check_batch("t5");
        send(CMD_DISARM, 1'b1);
        idle(4);
        check_batch("t6pre");
        bit_out(1'b0);
        bit_out(1'b0);
        bit_out(1'b0);
        rst = 1'b1;
        fpga_rx = 1'b1;
        @(negedge clk);
        chk("t6_dat", rx_dat, 0);
        chk("t6_stb", rx_stb, 0);
        chk("t6_dump", dump_req, 0);
        chk("t6_armed", armed, ARM_RST);
        chk("t6_busy", rx_busy, 0);
        rst = 1'b0;
        m_armed = ARM_RST;
        idle(SC);
        chk("t6_nothing", stb_b.size() + dump_t.size() + ferr_n, 0);
        send(CMD_DUMP, 1'b1);
        idle(4);
        check_batch("t6");
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: b = CMD_DUMP;
                1: b = CMD_ARM;
                2: b = CMD_DISARM;
                default: b = 8'($urandom);
            endcase
            send(b, 1'b1);
            idle($urandom_range(0, SC));
        end
        idle(4);
        check_batch("rnd");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
